// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   NOP_INST         : instruction presented when no valid head entry exists
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one fetch buffer slot {pc, inst, filled}
package if_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            filled;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// Ring buffer of fetch entries, one slot per request in flight.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : free every entry and rewind all pointers
//   alloc/alloc_pc: reserve the slot at the alloc pointer for a granted fetch
//   fill/fill_inst: write a returned word into the oldest unfilled slot
//   pop           : free the head slot
//   head          : head slot contents
//   alloc_cnt     : slots currently allocated (filled or not)
//   unfilled_cnt  : allocated slots still waiting for their word
module fetch_buffer
   import if_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   localparam int unsigned PW      = $clog2(DEPTH),
   localparam int unsigned CW      = PW + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               alloc,
   input  logic [XLEN-1:0]    alloc_pc,
   input  logic               fill,
   input  logic [XLEN-1:0]    fill_inst,
   input  logic               pop,
   output fetch_entry_t       head,
   output logic [CW-1:0]      alloc_cnt,
   output logic [CW-1:0]      unfilled_cnt
);

   fetch_entry_t  entries [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CW-1:0] alloc_ptr;
   logic [CW-1:0] fill_ptr;
   logic [CW-1:0] rd_ptr;
   logic [PW-1:0] alloc_idx;
   logic [PW-1:0] fill_idx;
   logic [PW-1:0] rd_idx;

   assign alloc_idx = alloc_ptr[PW-1:0];
   assign fill_idx  = fill_ptr[PW-1:0];
   assign rd_idx    = rd_ptr[PW-1:0];

   // Alloc, fill and pop always target distinct slots, so all three may act together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i] <= '{pc: RESET_PC, inst: NOP_INST, filled: 1'b0};
         end
      end else if (flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i].filled <= 1'b0;
         end
      end else begin
         if (alloc) begin
            entries[alloc_idx].pc     <= alloc_pc;
            entries[alloc_idx].filled <= 1'b0;
            alloc_ptr                 <= alloc_ptr + CW'(1);
         end
         if (fill) begin
            entries[fill_idx].inst   <= fill_inst;
            entries[fill_idx].filled <= 1'b1;
            fill_ptr                 <= fill_ptr + CW'(1);
         end
         if (pop) begin
            entries[rd_idx].filled <= 1'b0;
            rd_ptr                 <= rd_ptr + CW'(1);
         end
      end
   end

   assign head         = entries[rd_idx];
   assign alloc_cnt    = alloc_ptr - rd_ptr;
   assign unfilled_cnt = alloc_ptr - fill_ptr;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues in-order fetches and presents one
// instruction per cycle to IF/ID, honouring stall and redirect.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   PC_EN_IF                   : 1 lets IF/ID consume the head, 0 stalls
//   Branch_ID/branch_target_ID : redirect, flush and restart at target
//   imem_req/imem_addr/imem_gnt: fetch request handshake
//   imem_rvalid/imem_rdata     : in-order fetch responses
//   valid_IF/PC_IF/inst_IF     : head instruction to IF/ID (NOP when invalid)
// Optional: define IF_PERF_CNT_EN to add saturating perf_stall_cnt,
// perf_bubble_cnt and perf_redirect_cnt outputs.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_EN_IF,
   input  logic        Branch_ID,
   input  logic [31:0] branch_target_ID,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        valid_IF,
   output logic [31:0] PC_IF,
   output logic [31:0] inst_IF
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_bubble_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   pc_hold;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] alloc_cnt;
   logic [CW-1:0] unfilled_cnt;
   logic [CW:0]   occupancy;
   fetch_entry_t  head;
   logic          grant;
   logic          fill;
   logic          pop;

   // Dropped responses still hold a credit until they come back.
   assign occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
   assign imem_req  = rst_n & ~Branch_ID & (occupancy < (CW+1)'(FIFO_DEPTH));
   assign imem_addr = fetch_pc;
   assign grant     = imem_req & imem_gnt;
   assign fill      = imem_rvalid & ~Branch_ID & (drop_cnt == '0);
   assign valid_IF  = head.filled;
   assign pop       = PC_EN_IF & valid_IF & ~Branch_ID;
   assign inst_IF   = valid_IF ? head.inst : NOP_INST;
   assign PC_IF     = valid_IF ? head.pc : pc_hold;

   fetch_buffer #(
      .DEPTH    (FIFO_DEPTH),
      .RESET_PC (RESET_PC)
   ) u_fetch_buffer (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (Branch_ID),
      .alloc        (grant),
      .alloc_pc     (fetch_pc),
      .fill         (fill),
      .fill_inst    (imem_rdata),
      .pop          (pop),
      .head         (head),
      .alloc_cnt    (alloc_cnt),
      .unfilled_cnt (unfilled_cnt)
   );

   // Fetch PC, empty-buffer PC hold, and count of responses owed to a flushed stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         pc_hold  <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         if (Branch_ID) begin
            fetch_pc <= branch_target_ID;
         end else if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end

         if (valid_IF) begin
            pc_hold <= head.pc;
         end

         // On redirect every outstanding request becomes a drop, minus the one returning now.
         if (Branch_ID) begin
            drop_cnt <= drop_cnt + unfilled_cnt - CW'(imem_rvalid);
         end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt    <= '0;
         perf_bubble_cnt   <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (!PC_EN_IF && valid_IF && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (!valid_IF && !Branch_ID && (perf_bubble_cnt != '1)) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         end
         if (Branch_ID && (perf_redirect_cnt != '1)) begin
            perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed sequences with hand-derived
// expectations, an in-order memory model and a PC/instruction scoreboard.
module tb_if_fetch_unit;
   import if_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PC_EN_IF;
   logic        Branch_ID;
   logic [31:0] branch_target_ID;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        valid_IF;
   logic [31:0] PC_IF;
   logic [31:0] inst_IF;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_bubble_cnt;
   logic [31:0] perf_redirect_cnt;
`endif

   if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .PC_EN_IF         (PC_EN_IF),
      .Branch_ID        (Branch_ID),
      .branch_target_ID (branch_target_ID),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_gnt         (imem_gnt),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .valid_IF         (valid_IF),
      .PC_IF            (PC_IF),
      .inst_IF          (inst_IF)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_stall_cnt    (perf_stall_cnt),
      .perf_bubble_cnt   (perf_bubble_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pops     = 0;

   // Stimulus knobs read by step().
   logic        pc_en      = 1'b1;
   logic        br         = 1'b0;
   logic [31:0] br_tgt     = 32'h0;
   int          gnt_mode   = 0;   // 0 never, 1 always, 2 random 50%
   int          lat_min    = 1;
   int          lat_max    = 1;
   logic        rnd_pc_en  = 1'b0;
   logic [31:0] exp_pc     = RST_PC;

   // Memory model state: outstanding requests in grant order.
   logic [31:0] pend_addr [$];
   int          pend_rdy  [$];
   int          last_rdy  = 0;

   // First-cycles table after reset release (gnt=1, latency 1, no stall).
   logic        t1_req   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] t1_addr  [7] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};
   logic        t1_valid [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [31:0] t1_pc    [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC};

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive inputs at negedge, let combinational paths settle,
   // record grants into the memory model and run the scoreboard.
   task automatic step();
      int r;
      @(negedge clk);
      cyc++;
      PC_EN_IF         = rnd_pc_en ? ($urandom_range(3) != 0) : pc_en;
      Branch_ID        = br;
      branch_target_ID = br_tgt;
      case (gnt_mode)
         0:       imem_gnt = 1'b0;
         1:       imem_gnt = 1'b1;
         default: imem_gnt = 1'($urandom_range(1));
      endcase
      if (rst_n && (pend_rdy.size() > 0) && (pend_rdy[0] <= cyc)) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_rdy.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      if (imem_req && imem_gnt) begin
         r = cyc + int'($urandom_range(lat_max, lat_min));
         if (r <= last_rdy) r = last_rdy + 1;
         last_rdy = r;
         pend_addr.push_back(imem_addr);
         pend_rdy.push_back(r);
      end
      if (rst_n && valid_IF) begin
         check("sb_pc", PC_IF, exp_pc);
         check("sb_inst", inst_IF, mem_word(exp_pc));
      end
      if (Branch_ID) begin
         exp_pc = branch_target_ID;
      end else if (valid_IF && PC_EN_IF) begin
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
   endtask

   initial begin
      int pops0;
      rst_n            = 1'b0;
      PC_EN_IF         = 1'b1;
      Branch_ID        = 1'b0;
      branch_target_ID = 32'h0;
      imem_gnt         = 1'b0;
      imem_rvalid      = 1'b0;
      imem_rdata       = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid_IF), 32'd0);
      check("rst_pc", PC_IF, RST_PC);
      check("rst_inst", inst_IF, NOP_INST);
      check("rst_req", 32'(imem_req), 32'd0);

      // Streaming from reset release
      gnt_mode = 1; lat_min = 1; lat_max = 1; pc_en = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check("t1_req", 32'(imem_req), 32'(t1_req[i]));
         if (t1_req[i]) check("t1_addr", imem_addr, t1_addr[i]);
         check("t1_valid", 32'(valid_IF), 32'(t1_valid[i]));
         if (t1_valid[i]) check("t1_pc", PC_IF, t1_pc[i]);
      end

      // Stall with full buffer
      pc_en = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_req", 32'(imem_req), 32'd0);
         check("stall_valid", 32'(valid_IF), 32'd1);
         check("stall_pc", PC_IF, 32'h10);
         check("stall_inst", inst_IF, mem_word(32'h10));
      end
      pc_en = 1'b1;
      repeat (6) step();

      // Redirect with two requests in flight
      gnt_mode = 0;
      repeat (8) step();
      check("drain1_valid", 32'(valid_IF), 32'd0);
      gnt_mode = 1; lat_min = 3; lat_max = 3;
      step(); check("br1_req_a", 32'(imem_req), 32'd1);
      step(); check("br1_req_b", 32'(imem_req), 32'd1);
      br = 1'b1; br_tgt = 32'h100;
      step(); check("br1_req_br", 32'(imem_req), 32'd0);
      br = 1'b0;
      step(); check("br1_req_drop", 32'(imem_req), 32'd0);
      check("br1_valid_drop", 32'(valid_IF), 32'd0);
      step(); check("br1_req_tgt", 32'(imem_req), 32'd1);
      check("br1_addr_tgt", imem_addr, 32'h100);
      step(); check("br1_addr_next", imem_addr, 32'h104);
      step();
      step(); check("br1_valid_wait", 32'(valid_IF), 32'd0);
      step(); check("br1_valid", 32'(valid_IF), 32'd1);
      check("br1_pc", PC_IF, 32'h100);
      check("br1_inst", inst_IF, mem_word(32'h100));

      // Redirect during stall with a response arriving
      gnt_mode = 0;
      repeat (10) step();
      check("drain2_valid", 32'(valid_IF), 32'd0);
      gnt_mode = 1; lat_min = 1; lat_max = 1;
      step(); check("br2_req", 32'(imem_req), 32'd1);
      br = 1'b1; br_tgt = 32'h200; pc_en = 1'b0;
      step(); check("br2_req_br", 32'(imem_req), 32'd0);
      br = 1'b0; pc_en = 1'b1;
      step(); check("br2_addr", imem_addr, 32'h200);
      check("br2_valid_a", 32'(valid_IF), 32'd0);
      step(); check("br2_addr_next", imem_addr, 32'h204);
      check("br2_valid_b", 32'(valid_IF), 32'd0);
      step(); check("br2_valid", 32'(valid_IF), 32'd1);
      check("br2_pc", PC_IF, 32'h200);
      check("br2_inst", inst_IF, mem_word(32'h200));

      // Random grant, latency, stalls and occasional redirects
      gnt_mode = 2; lat_min = 1; lat_max = 3; rnd_pc_en = 1'b1;
      pops0 = pops;
      for (int i = 0; i < 400; i++) begin
         br     = ($urandom_range(39) == 0);
         br_tgt = $urandom() & 32'hFFFF_FFFC;
         step();
      end
      br = 1'b0; rnd_pc_en = 1'b0;
      check("rand_progress", 32'(pops - pops0 >= 50), 32'd1);

      // Asynchronous reset mid-stream
      gnt_mode = 1; lat_min = 1; lat_max = 1;
      repeat (5) step();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(valid_IF), 32'd0);
      check("arst_pc", PC_IF, RST_PC);
      check("arst_inst", inst_IF, NOP_INST);
      check("arst_req", 32'(imem_req), 32'd0);
      pend_addr.delete();
      pend_rdy.delete();
      last_rdy = 0;
      exp_pc   = RST_PC;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(); check("rel_req", 32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, RST_PC);
      step();
      step(); check("rel_valid", 32'(valid_IF), 32'd1);
      check("rel_pc", PC_IF, RST_PC);
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
